// File: rtl/sk_level_pkg.sv
// Shared level-tile definitions: map geometry, memory widths and pipeline owner tags.
package sk_level_pkg;
    localparam int TILE_SHIFT = 4;
    localparam int LVL_COLS   = 40;
    localparam int LVL_ROWS   = 30;
    localparam int ADDR_W     = 11;
    localparam int BLOCK_W    = 1;
    localparam int COORD_W    = 10;
    localparam int STARVE_MAX = 8;
    localparam int STARVE_W   = 4;

    localparam logic [BLOCK_W-1:0] OOB_BLOCK = BLOCK_W'(1);
    localparam logic [COORD_W-1:0] X_LIMIT   = COORD_W'(LVL_COLS << TILE_SHIFT);
    localparam logic [COORD_W-1:0] Y_LIMIT   = COORD_W'(LVL_ROWS << TILE_SHIFT);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_COL  = 2'd2
    } owner_e;

    // oob marks a granted slot that never touched memory and returns OOB_BLOCK
    typedef struct packed {
        logic   oob;
        owner_e owner;
    } tag_t;

    localparam tag_t TAG_EMPTY = '{oob: 1'b0, owner: TAG_NONE};
endpackage

// File: rtl/tile_addr_calc.sv
// Pixel coordinates to linear tile address plus off-map flag (purely combinational).
import sk_level_pkg::*;

module tile_addr_calc (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [ADDR_W-1:0]  addr,
    output logic               oob
);
    logic [ADDR_W-1:0] tx;
    logic [ADDR_W-1:0] ty;

    // Constant multiply by LVL_COLS, expanded into shifted partial sums
    function automatic logic [ADDR_W-1:0] mul_cols(input logic [ADDR_W-1:0] v);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int b = 0; b < ADDR_W; b++) begin
            if (LVL_COLS[b]) acc = acc + (v << b);
        end
        return acc;
    endfunction

    assign tx   = ADDR_W'(x >> TILE_SHIFT);
    assign ty   = ADDR_W'(y >> TILE_SHIFT);
    assign addr = mul_cols(ty) + tx;
    assign oob  = (x >= X_LIMIT) || (y >= Y_LIMIT);
endmodule

// File: rtl/level_port_arbiter.sv
// Arbitrates display and collision reads onto one level-tile memory, fixed 3-cycle latency.
// Optional LEVEL_ARB_STATS_EN adds saturating grant/miss counters.
//
// stage  | meaning
// EMPTY  | tag owner NONE, no read in flight
// ISSUED | tag1_q: address presented to memory (or OOB slot)
// RETURN | tag2_q: mem_rdata valid, captured into owner's output regs
import sk_level_pkg::*;

module level_port_arbiter (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               disp_req,
    input  logic [COORD_W-1:0] disp_x,
    input  logic [COORD_W-1:0] disp_y,
    output logic               disp_rvalid,
    output logic [BLOCK_W-1:0] disp_data,
    output logic               disp_miss,
    input  logic               col_req,
    input  logic [COORD_W-1:0] col_x,
    input  logic [COORD_W-1:0] col_y,
    output logic               col_gnt,
    output logic               col_rvalid,
    output logic [BLOCK_W-1:0] col_data,
    output logic               mem_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [BLOCK_W-1:0] mem_rdata,
    output logic               starve_err
`ifdef LEVEL_ARB_STATS_EN
    ,
    output logic [15:0]        col_grant_cnt,
    output logic [15:0]        disp_miss_cnt
`endif
);
    logic [ADDR_W-1:0]   disp_addr, col_addr, sel_addr;
    logic                disp_oob, col_oob, sel_oob;
    logic                starved, disp_win;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                starve_err_q;
    tag_t                tag1_q, tag1_d, tag2_q;
    logic                mem_en_q, mem_en_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                disp_rvalid_q, col_rvalid_q;
    logic [BLOCK_W-1:0]  disp_data_q, col_data_q, ret_data;

    tile_addr_calc u_disp_addr (.x(disp_x), .y(disp_y), .addr(disp_addr), .oob(disp_oob));
    tile_addr_calc u_col_addr  (.x(col_x),  .y(col_y),  .addr(col_addr),  .oob(col_oob));

    always_comb begin
        starved    = (starve_q == STARVE_W'(STARVE_MAX));
        // rst_n gating keeps the combinational grant quiet while reset is held
        disp_win   = rst_n && disp_req && !(starved && col_req);
        col_gnt    = rst_n && col_req && !disp_win;
        disp_miss  = disp_req && col_gnt;
        sel_addr   = disp_win ? disp_addr : col_addr;
        sel_oob    = disp_win ? disp_oob : col_oob;

        starve_d   = starve_q;
        if (!col_req || col_gnt) starve_d = '0;
        else if (!starved)       starve_d = starve_q + 1'b1;

        tag1_d     = TAG_EMPTY;
        mem_en_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        if (disp_win || col_gnt) begin
            tag1_d.owner = disp_win ? TAG_DISP : TAG_COL;
            tag1_d.oob   = sel_oob;
            mem_en_d     = !sel_oob;
            if (!sel_oob) mem_addr_d = sel_addr;
        end

        ret_data = tag2_q.oob ? OOB_BLOCK : mem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q      <= '0;
            starve_err_q  <= 1'b0;
            tag1_q        <= TAG_EMPTY;
            tag2_q        <= TAG_EMPTY;
            mem_en_q      <= 1'b0;
            mem_addr_q    <= '0;
            disp_rvalid_q <= 1'b0;
            col_rvalid_q  <= 1'b0;
            disp_data_q   <= '0;
            col_data_q    <= '0;
        end else begin
            starve_q      <= starve_d;
            starve_err_q  <= starve_err_q | disp_miss;
            tag1_q        <= tag1_d;
            tag2_q        <= tag1_q;
            mem_en_q      <= mem_en_d;
            mem_addr_q    <= mem_addr_d;
            disp_rvalid_q <= (tag2_q.owner == TAG_DISP);
            col_rvalid_q  <= (tag2_q.owner == TAG_COL);
            if (tag2_q.owner == TAG_DISP) disp_data_q <= ret_data;
            if (tag2_q.owner == TAG_COL)  col_data_q  <= ret_data;
        end
    end

    assign mem_en      = mem_en_q;
    assign mem_addr    = mem_addr_q;
    assign disp_rvalid = disp_rvalid_q;
    assign disp_data   = disp_data_q;
    assign col_rvalid  = col_rvalid_q;
    assign col_data    = col_data_q;
    assign starve_err  = starve_err_q;

`ifdef LEVEL_ARB_STATS_EN
    logic [15:0] col_grant_cnt_q, disp_miss_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_grant_cnt_q <= '0;
            disp_miss_cnt_q <= '0;
        end else begin
            if (col_gnt && (col_grant_cnt_q != 16'hFFFF))   col_grant_cnt_q <= col_grant_cnt_q + 1'b1;
            if (disp_miss && (disp_miss_cnt_q != 16'hFFFF)) disp_miss_cnt_q <= disp_miss_cnt_q + 1'b1;
        end
    end

    assign col_grant_cnt = col_grant_cnt_q;
    assign disp_miss_cnt = disp_miss_cnt_q;
`endif
endmodule

// File: tb/tb_level_port_arbiter.sv
// Directed bench for level_port_arbiter: reset, address mapping, starvation, off-map, pipelining.
module tb_level_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        disp_req, col_req;
    logic [9:0]  disp_x, disp_y, col_x, col_y;
    logic        disp_rvalid, disp_miss, col_gnt, col_rvalid, mem_en, starve_err;
    logic [0:0]  disp_data, col_data, mem_rdata;
    logic [10:0] mem_addr;
`ifdef LEVEL_ARB_STATS_EN
    logic [15:0] col_grant_cnt, disp_miss_cnt;
`endif

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    logic mon_en = 1'b0;
    int dq_data[$], dq_cyc[$], cq_data[$], cq_cyc[$];
    int d_ret, c_ret;

    always #5 clk = ~clk;

    level_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .disp_req(disp_req), .disp_x(disp_x), .disp_y(disp_y),
        .disp_rvalid(disp_rvalid), .disp_data(disp_data), .disp_miss(disp_miss),
        .col_req(col_req), .col_x(col_x), .col_y(col_y),
        .col_gnt(col_gnt), .col_rvalid(col_rvalid), .col_data(col_data),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .starve_err(starve_err)
`ifdef LEVEL_ARB_STATS_EN
        , .col_grant_cnt(col_grant_cnt), .disp_miss_cnt(disp_miss_cnt)
`endif
    );

    // Memory model: tile type = addr[0] ^ addr[2], one cycle after mem_en
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en) mem_rdata <= mem_addr[0] ^ mem_addr[2];
        else        mem_rdata <= 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_data(input int x, input int y);
        int a;
        if (x >= 640 || y >= 480) return 1;
        a = (y / 16) * 40 + (x / 16);
        return a[0] ^ a[2];
    endfunction

    task automatic run_starve(output int gnt_at, output int misses);
        gnt_at = 0;
        misses = 0;
        disp_req = 1'b1; disp_x = 10'd0;   disp_y = 10'd0;
        col_req  = 1'b1; col_x  = 10'd100; col_y  = 10'd100;
        for (int i = 1; i <= 12 && gnt_at == 0; i++) begin
            @(negedge clk);
            if (disp_miss) misses++;
            if (col_gnt) gnt_at = i;
            tick();
        end
        disp_req = 1'b0;
        col_req  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en && disp_rvalid) begin
            if (dq_data.size() == 0) chk("disp_extra_return", 1, 0);
            else begin
                chk("alt_disp_data", disp_data, dq_data.pop_front());
                chk("alt_disp_latency", cyc, dq_cyc.pop_front());
                d_ret++;
            end
        end
        if (mon_en && col_rvalid) begin
            if (cq_data.size() == 0) chk("col_extra_return", 1, 0);
            else begin
                chk("alt_col_data", col_data, cq_data.pop_front());
                chk("alt_col_latency", cyc, cq_cyc.pop_front());
                c_ret++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int gnt_at, misses, rv_seen, x, y;
        rst_n = 1'b0;
        disp_req = 1'b0; disp_x = '0; disp_y = '0;
        col_req  = 1'b0; col_x  = '0; col_y  = '0;

        // Reset: outputs zero, requests ignored
        repeat (2) @(posedge clk);
        #1 disp_req = 1'b1; col_req = 1'b1;
        @(negedge clk);
        chk("rst_col_gnt", col_gnt, 0);
        chk("rst_disp_miss", disp_miss, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rvalid", {disp_rvalid, col_rvalid}, 0);
        chk("rst_starve_err", starve_err, 0);
        disp_req = 1'b0; col_req = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // 1: reset while a read is in flight
        disp_req = 1'b1; disp_x = 10'd32; disp_y = 10'd16;
        tick();
        disp_req = 1'b0;
        rst_n = 1'b0;
        rv_seen = 0;
        @(negedge clk);
        chk("rst_mid_mem_en", mem_en, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (disp_rvalid || col_rvalid) rv_seen = 1;
            tick();
        end
        chk("rst_mid_no_rvalid", rv_seen, 0);

        // 2: display read, addr 81, data 1 at N+3
        disp_req = 1'b1; disp_x = 10'd17; disp_y = 10'd33;
        @(negedge clk);
        chk("disp_no_col_gnt", col_gnt, 0);
        tick();
        disp_req = 1'b0;
        @(negedge clk);
        chk("disp_mem_en", mem_en, 1);
        chk("disp_mem_addr", mem_addr, 81);
        tick();
        @(negedge clk);
        chk("disp_rvalid_early", disp_rvalid, 0);
        tick();
        @(negedge clk);
        chk("disp_rvalid", disp_rvalid, 1);
        chk("disp_data", disp_data, 1);
        tick();
        @(negedge clk);
        chk("disp_rvalid_pulse", disp_rvalid, 0);
        repeat (2) tick();

        // 3: collision read at the last tile
        col_req = 1'b1; col_x = 10'd639; col_y = 10'd479;
        @(negedge clk);
        chk("col_gnt", col_gnt, 1);
        tick();
        col_req = 1'b0;
        @(negedge clk);
        chk("col_mem_en", mem_en, 1);
        chk("col_mem_addr", mem_addr, 1199);
        repeat (2) tick();
        @(negedge clk);
        chk("col_rvalid", col_rvalid, 1);
        chk("col_data", col_data, 0);
        chk("col_no_disp_rvalid", disp_rvalid, 0);
        repeat (3) tick();

        // 4: starvation preemption on the 9th contended cycle
        chk("starve_err_before", starve_err, 0);
        run_starve(gnt_at, misses);
        @(negedge clk);
        chk("starve_gnt_cycle", gnt_at, 9);
        chk("starve_miss_count", misses, 1);
        chk("starve_err_set", starve_err, 1);
        repeat (4) tick();

        // 4b: dropping col_req clears the starvation count
        disp_req = 1'b1; col_req = 1'b1; col_x = 10'd100; col_y = 10'd100;
        repeat (5) tick();
        col_req = 1'b0;
        tick();
        run_starve(gnt_at, misses);
        chk("starve_clear_gnt_cycle", gnt_at, 9);
        repeat (4) tick();
        chk("starve_err_sticky", starve_err, 1);

        // 5: off-map reads, no memory access, OOB data returned
        col_req = 1'b1; col_x = 10'd640; col_y = 10'd0;
        @(negedge clk);
        chk("oob_col_gnt", col_gnt, 1);
        tick();
        col_req = 1'b0;
        disp_req = 1'b1; disp_x = 10'd0; disp_y = 10'd480;
        @(negedge clk);
        chk("oob_col_mem_en", mem_en, 0);
        tick();
        disp_req = 1'b0;
        @(negedge clk);
        chk("oob_disp_mem_en", mem_en, 0);
        tick();
        @(negedge clk);
        chk("oob_col_rvalid", col_rvalid, 1);
        chk("oob_col_data", col_data, 1);
        tick();
        @(negedge clk);
        chk("oob_disp_rvalid", disp_rvalid, 1);
        chk("oob_disp_data", disp_data, 1);
        repeat (3) tick();

        // 6: alternating display/collision, 100 cycles, fully pipelined
        d_ret = 0; c_ret = 0;
        mon_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            x = (i * 37) % 700;
            y = (i * 53) % 520;
            if (i % 2 == 0) begin
                disp_req = 1'b1; col_req = 1'b0;
                disp_x = 10'(x); disp_y = 10'(y);
                dq_data.push_back(exp_data(x, y));
                dq_cyc.push_back(cyc + 3);
            end else begin
                disp_req = 1'b0; col_req = 1'b1;
                col_x = 10'(x); col_y = 10'(y);
                cq_data.push_back(exp_data(x, y));
                cq_cyc.push_back(cyc + 3);
            end
            @(negedge clk);
            chk("alt_col_gnt", col_gnt, (i % 2 == 1) ? 1 : 0);
            tick();
        end
        disp_req = 1'b0; col_req = 1'b0;
        repeat (5) tick();
        mon_en = 1'b0;
        chk("alt_disp_returns", d_ret, 50);
        chk("alt_col_returns", c_ret, 50);
        chk("alt_queues_empty", dq_data.size() + cq_data.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
